// File: rtl/huffman_encode.sv
// Canonical Huffman encoder: walks JPEG-DHT style count/symbol tables to find a symbol's code.
// Optional macro HUFF_MSB_ALIGN_EN left-justifies the code output instead of right-justifying it.
module huffman_encode #(
  parameter int MAXLEN = 16,
  parameter int NSYM   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            symbol,
  input  logic [8*MAXLEN-1:0]   hufftable,
  input  logic [8*NSYM-1:0]     huffsymbol,
  output logic                  busy,
  output logic [MAXLEN-1:0]     code,
  output logic [4:0]            length,
  output logic                  finish,
  output logic                  notfound
);

  localparam int IW = $clog2(NSYM + 1);
  localparam int SW = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int TW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [4:0]        lvl_reg, lvl_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [IW-1:0]     idx_reg, idx_next;
  logic [MAXLEN-1:0] acc_reg, acc_next;
  logic [7:0]        sym_reg, sym_next;
  logic [MAXLEN-1:0] code_reg, code_next;
  logic [4:0]        length_reg, length_next;
  logic              notfound_reg, notfound_next;

  logic [7:0] table_bytes [MAXLEN];
  logic [7:0] sym_bytes [NSYM];

  genvar gi;
  generate
    for (gi = 0; gi < MAXLEN; gi++) begin : g_table
      assign table_bytes[gi] = hufftable[8*gi +: 8];
    end
    for (gi = 0; gi < NSYM; gi++) begin : g_sym
      assign sym_bytes[gi] = huffsymbol[8*gi +: 8];
    end
  endgenerate

  logic [MAXLEN-1:0] acc_aligned;
`ifdef HUFF_MSB_ALIGN_EN
  assign acc_aligned = acc_reg << (5'(MAXLEN) - lvl_reg);
`else
  assign acc_aligned = acc_reg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      lvl_reg      <= '0;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      acc_reg      <= '0;
      sym_reg      <= '0;
      code_reg     <= '0;
      length_reg   <= '0;
      notfound_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lvl_reg      <= lvl_next;
      cnt_reg      <= cnt_next;
      idx_reg      <= idx_next;
      acc_reg      <= acc_next;
      sym_reg      <= sym_next;
      code_reg     <= code_next;
      length_reg   <= length_next;
      notfound_reg <= notfound_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lvl_next      = lvl_reg;
    cnt_next      = cnt_reg;
    idx_next      = idx_reg;
    acc_next      = acc_reg;
    sym_next      = sym_reg;
    code_next     = code_reg;
    length_next   = length_reg;
    notfound_next = notfound_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          sym_next      = symbol;
          lvl_next      = 5'd1;
          cnt_next      = table_bytes[0];
          idx_next      = '0;
          acc_next      = '0;
          code_next     = '0;
          length_next   = '0;
          notfound_next = 1'b0;
          state_next    = SCAN;
        end
      end
      SCAN: begin
        if (cnt_reg == 8'd0 && lvl_reg == 5'(MAXLEN)) begin
          notfound_next = 1'b1;
          state_next    = DONE;
        end else if (cnt_reg == 8'd0) begin
          // Moving to the next length: the byte at the old level index is the new level's count.
          lvl_next = lvl_reg + 5'd1;
          acc_next = acc_reg << 1;
          cnt_next = table_bytes[lvl_reg[TW-1:0]];
        end else if (idx_reg == IW'(NSYM)) begin
          notfound_next = 1'b1;
          state_next    = DONE;
        end else if (sym_bytes[idx_reg[SW-1:0]] == sym_reg) begin
          code_next   = acc_aligned;
          length_next = lvl_reg;
          state_next  = DONE;
        end else begin
          idx_next = idx_reg + IW'(1);
          acc_next = acc_reg + MAXLEN'(1);
          cnt_next = cnt_reg - 8'd1;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy     = (state_reg == SCAN);
  assign finish   = (state_reg == DONE);
  assign code     = code_reg;
  assign length   = length_reg;
  assign notfound = notfound_reg;

endmodule

// File: tb/tb_huffman_encode.sv
// Scoreboard bench for huffman_encode: a software canonical encoder predicts code, length, miss and latency.
module tb_huffman_encode;
  localparam int MAXLEN = 16;
  localparam int NSYM   = 256;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [7:0]          symbol = '0;
  logic [8*MAXLEN-1:0] hufftable = '0;
  logic [8*NSYM-1:0]   huffsymbol = '0;
  logic                busy;
  logic [MAXLEN-1:0]   code;
  logic [4:0]          length;
  logic                finish;
  logic                notfound;

  huffman_encode #(.MAXLEN(MAXLEN), .NSYM(NSYM)) dut (
    .clk(clk), .rst(rst), .start(start), .symbol(symbol),
    .hufftable(hufftable), .huffsymbol(huffsymbol),
    .busy(busy), .code(code), .length(length), .finish(finish), .notfound(notfound)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0]  sym;
    logic [15:0] code;
    logic [4:0]  len;
    logic        nf;
    int          lat;
    int          scyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int counts[16];
  int syms[256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] align(input logic [15:0] c, input int l);
`ifdef HUFF_MSB_ALIGN_EN
    if (l == 0) return 16'h0;
    return c << (16 - l);
`else
    return c;
`endif
  endfunction

  // Software canonical encoder: enumerate codes length by length, first listed symbol wins.
  function automatic void model(input logic [7:0] s, output logic [15:0] c_o,
                                output logic [4:0] l_o, output logic nf_o, output int lat_o);
    longint c = 0;
    int k = 0;
    for (int l = 1; l <= 16; l++) begin
      for (int j = 0; j < counts[l-1]; j++) begin
        if (k == NSYM) begin
          c_o = 0; l_o = 0; nf_o = 1; lat_o = 2 + (l - 1) + NSYM + 1;
          return;
        end
        if (syms[k] == int'(s)) begin
          c_o = align(16'(c & 64'hFFFF), l); l_o = 5'(l); nf_o = 0;
          lat_o = 2 + (l - 1) + (k + 1);
          return;
        end
        k++;
        c++;
      end
      c = c << 1;
    end
    c_o = 0; l_o = 0; nf_o = 1; lat_o = 2 + 15 + k + 1;
  endfunction

  task automatic load_tables();
    for (int k = 0; k < 16; k++) hufftable[8*k +: 8] = 8'(counts[k]);
    for (int i = 0; i < NSYM; i++) huffsymbol[8*i +: 8] = 8'(syms[i]);
  endtask

  task automatic load_dc();
    int dc[16] = '{0, 1, 5, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 16; k++) counts[k] = dc[k];
    for (int i = 0; i < NSYM; i++) syms[i] = (i < 12) ? i : 8'hEE;
    load_tables();
  endtask

  // Directed entries carry spec constants for code/length/miss; latency always comes from the model.
  task automatic issue(input logic [7:0] s, input bit directed, input logic [15:0] dc,
                       input logic [4:0] dl, input logic dnf);
    exp_t e;
    model(s, e.code, e.len, e.nf, e.lat);
    if (directed) begin
      e.code = align(dc, int'(dl));
      e.len  = dl;
      e.nf   = dnf;
    end
    e.sym = s;
    @(posedge clk);
    #1;
    symbol = s;
    start  = 1'b1;
    e.scyc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_finish(input int budget);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      if (finish) break;
      n++;
    end
    if (n == budget) begin
      checks++;
      errors++;
      $display("FAIL finish_timeout: got no finish in %0d cycles, expected a finish", budget);
      sb.delete();
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && finish) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_finish: got finish with code=0x%0h, expected none", code);
      end else begin
        e = sb.pop_front();
        check("code", 32'(code), 32'(e.code));
        check("length", 32'(length), 32'(e.len));
        check("notfound", 32'(notfound), 32'(e.nf));
        check("latency", 32'(cyc - e.scyc + 1), 32'(e.lat));
        $display("txn sym=0x%02h code=0x%04h len=%0d nf=%0d lat=%0d", e.sym, code, length,
                 notfound, cyc - e.scyc + 1);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[256];
    int fin_cnt;
    int total;
    load_dc();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_code", 32'(code), 0);
    check("reset_length", 32'(length), 0);
    check("reset_finish", 32'(finish), 0);
    check("reset_notfound", 32'(notfound), 0);

    issue(8'h00, 1, 16'h0000, 5'd2, 1'b0); wait_finish(600);
    issue(8'h03, 1, 16'h0004, 5'd3, 1'b0); wait_finish(600);
    issue(8'h06, 1, 16'h000E, 5'd4, 1'b0); wait_finish(600);
    issue(8'h0B, 1, 16'h01FE, 5'd9, 1'b0); wait_finish(600);
    issue(8'h20, 1, 16'h0000, 5'd0, 1'b1); wait_finish(600);

    // Start pulsed mid-scan must be dropped; start during DONE must also be dropped.
    issue(8'h0B, 1, 16'h01FE, 5'd9, 1'b0);
    @(posedge clk); @(posedge clk);
    #1 symbol = 8'h00; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_finish(600);
    start = 1'b1; symbol = 8'h00;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("start_in_done_busy", 32'(busy), 0);
    check("hold_code", 32'(code), 32'(align(16'h01FE, 9)));
    check("hold_length", 32'(length), 9);

    // Reset during a scan: no finish, everything cleared.
    issue(8'h0B, 1, 16'h01FE, 5'd9, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_code", 32'(code), 0);
    check("abort_length", 32'(length), 0);
    check("abort_notfound", 32'(notfound), 0);
    fin_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (finish) fin_cnt++;
    end
    check("abort_no_finish", 32'(fin_cnt), 0);

    // Every symbol value against the DC table, in shuffled order.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      issue(8'(order[i]), 0, 16'h0, 5'd0, 1'b0);
      wait_finish(600);
    end

    // Random tables with duplicate symbols and occasional list overrun.
    for (int t = 0; t < 6; t++) begin
      total = 0;
      for (int k = 0; k < 16; k++) begin
        counts[k] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 24);
        total += counts[k];
      end
      for (int i = 0; i < NSYM; i++) syms[i] = $urandom_range(0, 255);
      load_tables();
      for (int n = 0; n < 30; n++) begin
        logic [7:0] s;
        if ($urandom_range(0, 1) == 1 && total > 0)
          s = 8'(syms[$urandom_range(0, (total > 256) ? 255 : total - 1)]);
        else
          s = 8'($urandom_range(0, 255));
        issue(s, 0, 16'h0, 5'd0, 1'b0);
        wait_finish(600);
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
